// File: rtl/pcie_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_pkg
//  Description : Shared encodings and defaults for the PCIE_trans VC pop path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcie_pkg;

    localparam int DEF_W_VC0 = 3;
    localparam int DEF_W_VC1 = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CFG  = 2'd1,
        S_VC0  = 2'd2,
        S_VC1  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/wrr_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_credit_counter
//  Description : Load / decrement down-counter with a last-credit flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrr_credit_counter #(
    parameter int W_BITS = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              clear,
    input  logic              load,
    input  logic [W_BITS-1:0] load_val,
    input  logic              dec,
    output logic [W_BITS-1:0] credit,
    output logic              last
);

    logic [W_BITS-1:0] r_credit;

    // clear beats load so a reconfiguration always discards a pending grant
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_credit <= '0;
        end else if (clear) begin
            r_credit <= '0;
        end else if (load) begin
            r_credit <= load_val;
        end else if (dec && (r_credit != '0)) begin
            r_credit <= r_credit - W_BITS'(1);
        end
    end

    assign credit = r_credit;
    assign last   = (r_credit == W_BITS'(1));

endmodule
`default_nettype wire

// File: rtl/vc_pop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : vc_pop_scheduler
//  Description : Weighted round-robin pop scheduler for the VC0/VC1 FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_pop_scheduler #(
    parameter int W_BITS    = 4,
    parameter int DEF_W_VC0 = pcie_pkg::DEF_W_VC0,
    parameter int DEF_W_VC1 = pcie_pkg::DEF_W_VC1,
    parameter int CNT_BITS  = 8
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [W_BITS-1:0]   peso_vc0,
    input  logic [W_BITS-1:0]   peso_vc1,
    input  logic                Fifo_Empty_VC0,
    input  logic                Fifo_Empty_VC1,
    input  logic                Pausa_D0,
    input  logic                Pausa_D1,
    output logic                pop_vc0,
    output logic                pop_vc1,
    output logic                grant_vc,
    output logic [1:0]          sched_state,
    output logic [CNT_BITS-1:0] pops_vc0,
    output logic [CNT_BITS-1:0] pops_vc1
);

    import pcie_pkg::*;

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic [W_BITS-1:0]   r_w0;
    logic [W_BITS-1:0]   r_w1;
    logic                r_pausa_q;
    logic [CNT_BITS-1:0] r_pops_vc0;
    logic [CNT_BITS-1:0] r_pops_vc1;

    logic                w_pop_vc0;
    logic                w_pop_vc1;
    logic                w_cr_clear;
    logic                w_cr_load;
    logic [W_BITS-1:0]   w_cr_load_val;
    logic                w_cr_dec;
    logic [W_BITS-1:0]   w_credit;
    logic                w_cr_last;

    // A programmed weight of zero still grants one pop per turn
    function automatic logic [W_BITS-1:0] eff_weight(input logic [W_BITS-1:0] w);
        return (w == '0) ? W_BITS'(1) : w;
    endfunction

    assign w_pop_vc0 = (r_state == S_VC0) && !Fifo_Empty_VC0 && !r_pausa_q;
    assign w_pop_vc1 = (r_state == S_VC1) && !Fifo_Empty_VC1 && !r_pausa_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= S_IDLE;
            r_w0       <= W_BITS'(DEF_W_VC0);
            r_w1       <= W_BITS'(DEF_W_VC1);
            r_pausa_q  <= 1'b0;
            r_pops_vc0 <= '0;
            r_pops_vc1 <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pausa_q <= Pausa_D0 | Pausa_D1;
            if (r_state == S_CFG) begin
                r_w0 <= peso_vc0;
                r_w1 <= peso_vc1;
            end
            if (w_pop_vc0) begin
                r_pops_vc0 <= r_pops_vc0 + CNT_BITS'(1);
            end
            if (w_pop_vc1) begin
                r_pops_vc1 <= r_pops_vc1 + CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cr_clear    = 1'b0;
        w_cr_load     = 1'b0;
        w_cr_load_val = '0;
        w_cr_dec      = 1'b0;

        if (init) begin
            w_state_nxt = S_CFG;
            w_cr_clear  = 1'b1;
        end else if (r_state == S_CFG) begin
            w_state_nxt = S_IDLE;
        end else if (!r_pausa_q) begin
            // Pause holds the current grant and credit untouched
            case (r_state)
                S_IDLE: begin
                    if (!Fifo_Empty_VC0) begin
                        w_state_nxt   = S_VC0;
                        w_cr_load     = 1'b1;
                        w_cr_load_val = eff_weight(r_w0);
                    end else if (!Fifo_Empty_VC1) begin
                        w_state_nxt   = S_VC1;
                        w_cr_load     = 1'b1;
                        w_cr_load_val = eff_weight(r_w1);
                    end
                end
                S_VC0: begin
                    w_cr_dec = w_pop_vc0;
                    if ((w_pop_vc0 && w_cr_last) || Fifo_Empty_VC0) begin
                        if (!Fifo_Empty_VC1) begin
                            w_state_nxt   = S_VC1;
                            w_cr_load     = 1'b1;
                            w_cr_load_val = eff_weight(r_w1);
                        end else if (!Fifo_Empty_VC0) begin
                            w_cr_load     = 1'b1;
                            w_cr_load_val = eff_weight(r_w0);
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_VC1: begin
                    w_cr_dec = w_pop_vc1;
                    if ((w_pop_vc1 && w_cr_last) || Fifo_Empty_VC1) begin
                        if (!Fifo_Empty_VC0) begin
                            w_state_nxt   = S_VC0;
                            w_cr_load     = 1'b1;
                            w_cr_load_val = eff_weight(r_w0);
                        end else if (!Fifo_Empty_VC1) begin
                            w_cr_load     = 1'b1;
                            w_cr_load_val = eff_weight(r_w1);
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    wrr_credit_counter #(
        .W_BITS (W_BITS)
    ) u_credit (
        .clk      (clk),
        .reset_L  (reset_L),
        .clear    (w_cr_clear),
        .load     (w_cr_load),
        .load_val (w_cr_load_val),
        .dec      (w_cr_dec),
        .credit   (w_credit),
        .last     (w_cr_last)
    );

    assign pop_vc0     = w_pop_vc0;
    assign pop_vc1     = w_pop_vc1;
    assign grant_vc    = (r_state == S_VC1);
    assign sched_state = r_state;
    assign pops_vc0    = r_pops_vc0;
    assign pops_vc1    = r_pops_vc1;

endmodule
`default_nettype wire

// File: tb/tb_vc_pop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_pop_scheduler
//  Description : Scoreboard bench for vc_pop_scheduler against a queue-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_pop_scheduler;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       init = 1'b0;
    logic [3:0] peso_vc0 = 4'd0;
    logic [3:0] peso_vc1 = 4'd0;
    logic       Fifo_Empty_VC0 = 1'b1;
    logic       Fifo_Empty_VC1 = 1'b1;
    logic       Pausa_D0 = 1'b0;
    logic       Pausa_D1 = 1'b0;
    logic       pop_vc0;
    logic       pop_vc1;
    logic       grant_vc;
    logic [1:0] sched_state;
    logic [7:0] pops_vc0;
    logic [7:0] pops_vc1;

    vc_pop_scheduler dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .peso_vc0       (peso_vc0),
        .peso_vc1       (peso_vc1),
        .Fifo_Empty_VC0 (Fifo_Empty_VC0),
        .Fifo_Empty_VC1 (Fifo_Empty_VC1),
        .Pausa_D0       (Pausa_D0),
        .Pausa_D1       (Pausa_D1),
        .pop_vc0        (pop_vc0),
        .pop_vc1        (pop_vc1),
        .grant_vc       (grant_vc),
        .sched_state    (sched_state),
        .pops_vc0       (pops_vc0),
        .pops_vc1       (pops_vc1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p0;
        int p1;
        int st;
        int gv;
        int c0;
        int c1;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: owner 0=idle 1=config 2=VC0 3=VC1, remaining turn pops
    int m_owner, m_left, m_w0, m_w1, m_pause, m_c0, m_c1;
    int occ0 = 0;
    int occ1 = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int turn(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_left = 0; m_w0 = 3; m_w1 = 1;
        m_pause = 0; m_c0 = 0; m_c1 = 0;
    endtask

    // One clock: present FIFO status, predict outputs, advance model, step edge
    task automatic tick();
        exp_t e;
        bit   e0, e1, take0, take1, done;
        Fifo_Empty_VC0 = (occ0 == 0);
        Fifo_Empty_VC1 = (occ1 == 0);
        e0 = (occ0 == 0);
        e1 = (occ1 == 0);
        if (!reset_L) begin
            model_reset();
            e = '{0, 0, 0, 0, 0, 0};
        end else begin
            take0 = (m_owner == 2) && !e0 && (m_pause == 0);
            take1 = (m_owner == 3) && !e1 && (m_pause == 0);
            e = '{int'(take0), int'(take1), m_owner, int'(m_owner == 3), m_c0, m_c1};
            if (take0) begin occ0--; m_c0 = (m_c0 + 1) % 256; end
            if (take1) begin occ1--; m_c1 = (m_c1 + 1) % 256; end
            if (init) begin
                if (m_owner == 1) begin m_w0 = peso_vc0; m_w1 = peso_vc1; end
                m_owner = 1; m_left = 0;
            end else if (m_owner == 1) begin
                m_w0 = peso_vc0; m_w1 = peso_vc1; m_owner = 0;
            end else if (m_pause == 0) begin
                if (m_owner == 0) begin
                    if (!e0)      begin m_owner = 2; m_left = turn(m_w0); end
                    else if (!e1) begin m_owner = 3; m_left = turn(m_w1); end
                end else if (m_owner == 2) begin
                    if (take0) m_left--;
                    done = (take0 && m_left == 0) || e0;
                    if (done) begin
                        if (!e1)      begin m_owner = 3; m_left = turn(m_w1); end
                        else if (!e0) begin m_left = turn(m_w0); end
                        else          m_owner = 0;
                    end
                end else begin
                    if (take1) m_left--;
                    done = (take1 && m_left == 0) || e1;
                    if (done) begin
                        if (!e0)      begin m_owner = 2; m_left = turn(m_w0); end
                        else if (!e1) begin m_left = turn(m_w1); end
                        else          m_owner = 0;
                    end
                end
            end
            m_pause = int'(Pausa_D0 | Pausa_D1);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    // Monitor: compares every presented cycle against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pop_vc0", int'(pop_vc0), e.p0);
                chk("pop_vc1", int'(pop_vc1), e.p1);
                chk("sched_state", int'(sched_state), e.st);
                chk("grant_vc", int'(grant_vc), e.gv);
                chk("pops_vc0", int'(pops_vc0), e.c0);
                chk("pops_vc1", int'(pops_vc1), e.c1);
            end
        end
    end

    initial begin
        int init_len;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with both VCs empty, then idle
        repeat (4) tick();
        reset_L = 1'b1;
        repeat (10) tick();

        // Default 3/1 weights, both loaded
        occ0 = 8; occ1 = 8;
        repeat (22) tick();

        // Reconfigure to 2/2
        init = 1'b1; peso_vc0 = 4'd2; peso_vc1 = 4'd2;
        occ0 = 8; occ1 = 8;
        repeat (3) tick();
        init = 1'b0;
        repeat (22) tick();

        // Pause pulse in the middle of a VC0 burst
        occ0 = 20; occ1 = 0;
        repeat (4) tick();
        Pausa_D1 = 1'b1;
        repeat (3) tick();
        Pausa_D1 = 1'b0;
        repeat (12) tick();

        // Zero weights with a single VC1 entry
        occ0 = 0; occ1 = 0;
        sync_reset();
        init = 1'b1; peso_vc0 = 4'd0; peso_vc1 = 4'd0;
        repeat (2) tick();
        init = 1'b0;
        tick();
        occ1 = 1;
        repeat (6) tick();

        // Asynchronous reset mid-burst, then wrap the pop counters
        occ0 = 10; occ1 = 10;
        repeat (5) tick();
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_pop_vc0", int'(pop_vc0), 0);
        chk("async_pop_vc1", int'(pop_vc1), 0);
        chk("async_state", int'(sched_state), 0);
        tick();
        tick();
        reset_L = 1'b1;
        occ0 = 150; occ1 = 150;
        repeat (320) tick();
        chk("wrap_pops_vc0", int'(pops_vc0), 150 % 256);
        chk("wrap_total", (int'(pops_vc0) + int'(pops_vc1)) % 256, 300 % 256);

        // Randomized traffic, pauses and reconfiguration
        init_len = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3, 0) == 0) occ0 += $urandom_range(3, 0);
            if ($urandom_range(3, 0) == 0) occ1 += $urandom_range(3, 0);
            Pausa_D0 = ($urandom_range(9, 0) == 0);
            Pausa_D1 = ($urandom_range(9, 0) == 0);
            if (init_len == 0 && $urandom_range(63, 0) == 0) begin
                init_len = $urandom_range(3, 1);
                peso_vc0 = 4'($urandom_range(15, 0));
                peso_vc1 = 4'($urandom_range(15, 0));
            end
            init = (init_len > 0);
            if (init_len > 0) init_len--;
            tick();
        end
        init = 1'b0; Pausa_D0 = 1'b0; Pausa_D1 = 1'b0;

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
